// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
//
// Parametrised UART receiver. Supports 5..8 data bits, optional odd/even
// parity, mid-bit sampling with false-start rejection, and break handling.
// Good frames are pushed into a small circular FIFO that a consumer drains
// through a valid/ready handshake. Error conditions are reported as
// one-cycle pulses. An optional running byte checksum is built only when
// the macro UART_RX_FRAMED_SUM_EN is defined; otherwise o_sum is tied to 0.
//
// Parameters
//   CYCLES_PER_BIT  clocks per serial bit (>= 3)
//   DATA_BITS       data bits per frame (5..8)
//   PARITY          0 none, 1 odd, 2 even
//   FIFO_DEPTH      received-byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   i_serial      serial line, idle high, asynchronous to clk
//   o_data        FIFO head byte, zero-extended above DATA_BITS
//   o_valid       FIFO non-empty
//   i_ready       consumer ready
//   o_frame_err   one-cycle pulse: stop bit sampled 0
//   o_parity_err  one-cycle pulse: parity mismatch
//   o_overrun     one-cycle pulse: good frame dropped, FIFO full
//   o_sum         running sum of bytes pushed into the FIFO
//
// Handshake: a byte transfers on every clk edge where o_valid and i_ready
// are both high. o_valid never depends combinationally on i_ready, and
// o_data stays stable while o_valid is high and i_ready is low.
//
// Debug: the receive FSM state is held in state_q (encoding below) so a
// checker can observe it hierarchically.
// ---------------------------------------------------------------------------
module uart_rx_framed #(
  parameter int CYCLES_PER_BIT = 4,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_serial,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_frame_err,
  output logic        o_parity_err,
  output logic        o_overrun,
  output logic [31:0] o_sum
);

  localparam int CW   = $clog2(CYCLES_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   CYC_FULL = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0]   CYC_HALF = CW'((CYCLES_PER_BIT - 1) / 2);
  localparam logic [2:0]      LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic            PAR_ODD  = (PARITY == 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  // -------------------------------------------------------------------------
  // Input synchroniser; both flops reset to the idle (high) line level.
  // -------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM
  // -------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CW-1:0]          cycle_q, cycle_d;
  logic [2:0]             index_q, index_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_bad_q, parity_bad_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   push_req;
  logic                   tick;

  assign tick = (cycle_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cycle_q      <= '0;
      index_q      <= '0;
      shift_q      <= '0;
      parity_bad_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      parity_bad_q <= parity_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    index_d      = index_q;
    shift_d      = shift_q;
    parity_bad_d = parity_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push_req     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          // Half a bit ahead so the start bit is re-checked near its middle.
          cycle_d      = CYC_HALF;
          parity_bad_d = 1'b0;
          state_d      = ST_START;
        end
      end

      ST_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            cycle_d = CYC_FULL;
            index_d = 3'd0;
            state_d = ST_DATA;
          end else begin
            // Line went back high: treat as a glitch, silently re-arm.
            state_d = ST_IDLE;
          end
        end else begin
          cycle_d = cycle_q - CW'(1);
        end
      end

      ST_DATA: begin
        if (tick) begin
          // LSB arrives first, so bits enter at the top and walk down.
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cycle_d = CYC_FULL;
          index_d = index_q + 3'd1;
          if (index_q == LAST_IDX) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end
        end else begin
          cycle_d = cycle_q - CW'(1);
        end
      end

      ST_PARITY: begin
        if (tick) begin
          // Odd parity wants an odd total count of ones, even wants zero.
          parity_bad_d = (((^shift_q) ^ rx_s_q) != PAR_ODD);
          cycle_d      = CYC_FULL;
          state_d      = ST_STOP;
        end else begin
          cycle_d = cycle_q - CW'(1);
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (!rx_s_q) begin
            // Framing error wins over parity error.
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end else if (parity_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          cycle_d = cycle_q - CW'(1);
        end
      end

      ST_BREAK: begin
        // A held-low line must return high before a new start is accepted.
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Received-byte FIFO
  // -------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CNTW-1:0] count_q;
  logic [7:0]      push_byte;
  logic            pop;
  logic            full;
  logic            push_ok;

  always_comb begin
    push_byte                = '0;
    push_byte[DATA_BITS-1:0] = shift_q;
  end

  assign pop  = (count_q != '0) && i_ready;
  assign full = (count_q == CNT_FULL);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!full || pop);
  assign overrun_d = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= push_byte;
        tail_q        <= tail_q + AW'(1);
      end
      if (pop) begin
        head_q <= head_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_data       = mem_q[head_q];
  assign o_valid      = (count_q != '0);
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overrun    = overrun_q;

  // -------------------------------------------------------------------------
  // Optional running checksum of accepted bytes
  // -------------------------------------------------------------------------
`ifdef UART_RX_FRAMED_SUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (push_ok) begin
      sum_q <= sum_q + {24'd0, push_byte};
    end
  end

  assign o_sum = sum_q;
`else
  assign o_sum = 32'd0;
`endif

endmodule
